matrix_result_unloader: RTL and testbench

Drains 2x2 result matrices from the systolic multiplier's four result registers (z11, z12, z21, z22) and streams them out one element per beat over a valid/ready interface. It sits between the multiplier core and the bus-side readback logic. It buffers up to DEPTH complete result sets so the core can start the next product while earlier results are still being read. Sets that arrive while the buffer is full are dropped and counted.

---
 rtl/matrix_pkg.sv | 13 +
 rtl/matrix_result_fifo.sv | 42 ++++
 rtl/matrix_result_unloader.sv | 82 ++++++++
 tb/tb_matrix_result_unloader.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_pkg.sv
// matrix_pkg: shared widths and types for the matrix multiplier and its result unloader
package matrix_pkg;
  localparam int indata_size = 8;
  localparam int RES_W = 4 * indata_size;
  typedef struct packed {
    logic signed [RES_W-1:0] z11;
    logic signed [RES_W-1:0] z12;
    logic signed [RES_W-1:0] z21;
    logic signed [RES_W-1:0] z22;
  } result_set_t;
  typedef enum logic [1:0] {E11, E12, E21, E22} elem_idx_e;
  typedef enum logic {IDLE, STREAM} state_e;
endpackage

// File: rtl/matrix_result_fifo.sv
// matrix_result_fifo: DEPTH-entry FIFO of complete result sets
// Ports: wr_en/wr_data push a set (ignored when full), rd_en pops the head,
// rd_data is the head set, cnt is occupancy 0..DEPTH, full = (cnt == DEPTH).
module matrix_result_fifo
  import matrix_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  result_set_t   wr_data,
  input  logic          rd_en,
  output result_set_t   rd_data,
  output logic [CW-1:0] cnt,
  output logic          full
);
  result_set_t mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] cnt_q;
  logic wr;
  assign full = cnt_q == CW'(DEPTH);
  assign wr = wr_en && !full;
  assign cnt = cnt_q;
  assign rd_data = mem_q[rd_ptr_q];
  // Storage carries no reset; stale slots are never presented because
  // occupancy gates what the reader may look at.
  always_ff @(posedge clk)
    if (wr) mem_q[wr_ptr_q] <= wr_data;
  always_ff @(posedge clk)
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      if (wr) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q <= cnt_q + CW'(wr) - CW'(rd_en);
    end
endmodule

// File: rtl/matrix_result_unloader.sv
// matrix_result_unloader: buffers 2x2 result sets and streams them one element per beat
// Ports: res_valid + z11..z22 deliver a set from the core; res_ready advises a free slot;
// out_data/out_valid/out_ready/out_idx/out_last form the element stream;
// overflow/drop_cnt report dropped sets and are cleared by ovf_clear.
module matrix_result_unloader #(
  parameter int DEPTH = 2,
  parameter int RES_W = matrix_pkg::RES_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    res_valid,
  input  logic signed [RES_W-1:0] z11,
  input  logic signed [RES_W-1:0] z12,
  input  logic signed [RES_W-1:0] z21,
  input  logic signed [RES_W-1:0] z22,
  output logic                    res_ready,
  output logic        [RES_W-1:0] out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic              [1:0] out_idx,
  output logic                    out_last,
  output logic                    overflow,
  input  logic                    ovf_clear,
  output logic              [7:0] drop_cnt
);
  import matrix_pkg::*;
  localparam int CW = $clog2(DEPTH + 1);
  state_e state_q, state_d;
  elem_idx_e word_idx_q, word_idx_d;
  logic overflow_q, overflow_d;
  logic [7:0] drop_cnt_q, drop_cnt_d;
  logic [CW-1:0] cnt;
  logic full, capture, drop, xfer, pop;
  result_set_t in_set, head;
  assign in_set = '{z11: z11, z12: z12, z21: z21, z22: z22};
  // Full is judged on registered occupancy, so a set arriving as the head
  // set finishes is still dropped.
  assign capture = res_valid && !full;
  assign drop = res_valid && full;
  assign xfer = out_valid && out_ready;
  assign pop = xfer && word_idx_q == E22;
  matrix_result_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (capture),
    .wr_data (in_set),
    .rd_en   (pop),
    .rd_data (head),
    .cnt     (cnt),
    .full    (full)
  );
  always_comb begin
    state_d = state_q == IDLE ? (capture ? STREAM : IDLE)
            : (pop && cnt == CW'(1) && !capture ? IDLE : STREAM);
    word_idx_d = xfer ? elem_idx_e'(word_idx_q + 2'd1) : word_idx_q;
    overflow_d = drop || (!ovf_clear && overflow_q);
    drop_cnt_d = ovf_clear ? {7'd0, drop}
               : drop && drop_cnt_q != 8'hFF ? drop_cnt_q + 8'd1 : drop_cnt_q;
  end
  always_ff @(posedge clk)
    if (reset) begin
      state_q <= IDLE;
      word_idx_q <= E11;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      word_idx_q <= word_idx_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  assign out_valid = state_q == STREAM;
  assign out_idx = word_idx_q;
  assign out_last = word_idx_q == E22;
  assign out_data = !out_valid ? '0
                  : word_idx_q == E11 ? head.z11
                  : word_idx_q == E12 ? head.z12
                  : word_idx_q == E21 ? head.z21 : head.z22;
  assign res_ready = !full;
  assign overflow = overflow_q;
  assign drop_cnt = drop_cnt_q;
endmodule

// File: tb/tb_matrix_result_unloader.sv
// tb_matrix_result_unloader: table-driven and scoreboard checks of the result unloader
module tb_matrix_result_unloader;
  logic clk = 1'b0;
  logic reset, res_valid, out_ready, ovf_clear;
  logic signed [31:0] z11, z12, z21, z22;
  logic res_ready, out_valid, out_last, overflow;
  logic [31:0] out_data;
  logic [1:0] out_idx;
  logic [7:0] drop_cnt;
  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] d;
    logic [1:0]  i;
    logic        l;
  } beat_t;
  beat_t q[$];

  typedef struct packed {
    logic [127:0] z;
    logic         rdy;
    logic         stored;
    logic         drain;
    logic         er;
    logic         eo;
    logic [7:0]   ed;
  } row_t;
  row_t rows[4];

  matrix_result_unloader #(.DEPTH(2)) dut (
    .clk(clk), .reset(reset), .res_valid(res_valid),
    .z11(z11), .z12(z12), .z21(z21), .z22(z22),
    .res_ready(res_ready), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_idx(out_idx), .out_last(out_last),
    .overflow(overflow), .ovf_clear(ovf_clear), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic row_t mk(input logic [127:0] z, input logic rdy, input logic stored,
                              input logic drain, input logic er, input logic eo,
                              input logic [7:0] ed);
    row_t r;
    r.z = z; r.rdy = rdy; r.stored = stored; r.drain = drain;
    r.er = er; r.eo = eo; r.ed = ed;
    return r;
  endfunction

  task automatic strobe(input logic [127:0] s, input logic stored);
    res_valid = 1'b1;
    z11 = s[127:96]; z12 = s[95:64]; z21 = s[63:32]; z22 = s[31:0];
    if (stored)
      for (int i = 0; i < 4; i++) begin
        beat_t b;
        b.d = s[127-32*i -: 32];
        b.i = 2'(i);
        b.l = (i == 3);
        q.push_back(b);
      end
    tick();
    res_valid = 1'b0;
  endtask

  task automatic drain(input logic bp);
    logic pat[4];
    int k = 0;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    while ((q.size() != 0 || out_valid) && k < 200) begin
      out_ready = bp ? pat[k % 4] : 1'b1;
      tick();
      k++;
    end
    out_ready = 1'b1;
    chk("drain_queue_empty", 64'(q.size()), 64'd0);
    chk("drain_valid_low", 64'(out_valid), 64'd0);
  endtask

  task automatic wait_idx(input logic [1:0] n);
    int k = 0;
    while (out_idx != n && k < 20) begin
      tick();
      k++;
    end
    chk("wait_idx", 64'(out_idx), 64'(n));
  endtask

  // Scoreboard monitor: a beat is compared at the negedge before the edge that transfers it;
  // a stalled beat must look identical one cycle later.
  logic stall_q = 1'b0;
  logic [34:0] held;
  always @(negedge clk) begin
    if (!reset && stall_q) begin
      chk("stall_valid", 64'(out_valid), 64'd1);
      chk("stall_hold", 64'({out_data, out_idx, out_last}), 64'(held));
    end
    if (!reset && out_valid && out_ready) begin
      if (q.size() == 0) chk("unexpected_beat", 64'({out_data, out_idx, out_last}), 64'd0 - 1);
      else begin
        beat_t e;
        e = q.pop_front();
        chk("beat", 64'({out_data, out_idx, out_last}), 64'(e));
      end
    end
    stall_q = !reset && out_valid && !out_ready;
    held = {out_data, out_idx, out_last};
  end

  localparam logic [127:0] SA = {32'h00000001, 32'hFFFFFFFE, 32'h7FFFFFFF, 32'h80000000};
  localparam logic [127:0] SB = {32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
  localparam logic [127:0] SC = {32'hA5A5A5A5, 32'h5A5A5A5A, 32'hDEADBEEF, 32'h01234567};
  localparam logic [127:0] SD = {32'hCAFEF00D, 32'h0BADC0DE, 32'hFFFF0000, 32'h0000FFFF};
  localparam logic [127:0] SE = {32'h00000010, 32'h00000020, 32'h00000030, 32'h00000040};
  localparam logic [127:0] SF = {32'hF0000001, 32'hF0000002, 32'hF0000003, 32'hF0000004};

  initial begin
    logic empty;
    reset = 1'b1; res_valid = 1'b0; out_ready = 1'b1; ovf_clear = 1'b0;
    z11 = '0; z12 = '0; z21 = '0; z22 = '0;
    tick(); tick();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_idx", 64'(out_idx), 64'd0);
    chk("rst_out_last", 64'(out_last), 64'd0);
    chk("rst_res_ready", 64'(res_ready), 64'd1);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);
    reset = 1'b0;
    tick();

    rows[0] = mk(SA, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0);
    rows[1] = mk(SB, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0);
    rows[2] = mk(SC, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
    rows[3] = mk(SD, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'd1);
    for (int i = 0; i < 4; i++) begin
      out_ready = rows[i].rdy;
      empty = q.size() == 0 && !out_valid;
      strobe(rows[i].z, rows[i].stored);
      chk("row_res_ready", 64'(res_ready), 64'(rows[i].er));
      chk("row_overflow", 64'(overflow), 64'(rows[i].eo));
      chk("row_drop_cnt", 64'(drop_cnt), 64'(rows[i].ed));
      if (empty && rows[i].stored) begin
        chk("first_valid", 64'(out_valid), 64'd1);
        chk("first_data", 64'(out_data), 64'(rows[i].z[127:96]));
      end
      if (rows[i].drain) drain(1'b0);
    end

    ovf_clear = 1'b1; tick(); ovf_clear = 1'b0;
    chk("clr_overflow", 64'(overflow), 64'd0);
    chk("clr_drop_cnt", 64'(drop_cnt), 64'd0);

    out_ready = 1'b1;
    strobe(SC, 1'b1);
    drain(1'b1);

    strobe(SE, 1'b1);
    wait_idx(2'd3);
    strobe(SF, 1'b1);
    chk("sim1_res_ready", 64'(res_ready), 64'd1);
    chk("sim1_valid", 64'(out_valid), 64'd1);
    chk("sim1_no_gap", 64'({out_data, out_idx}), 64'({SF[127:96], 2'd0}));
    drain(1'b0);

    out_ready = 1'b0;
    strobe(SA, 1'b1);
    strobe(SB, 1'b1);
    chk("full_res_ready", 64'(res_ready), 64'd0);
    out_ready = 1'b1;
    wait_idx(2'd3);
    strobe(SD, 1'b0);
    chk("simfull_overflow", 64'(overflow), 64'd1);
    chk("simfull_drop_cnt", 64'(drop_cnt), 64'd1);
    chk("simfull_res_ready", 64'(res_ready), 64'd1);
    chk("simfull_next", 64'({out_data, out_idx}), 64'({SB[127:96], 2'd0}));
    drain(1'b0);

    strobe(SC, 1'b1);
    wait_idx(2'd2);
    reset = 1'b1; out_ready = 1'b0;
    q.delete();
    tick();
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_data", 64'(out_data), 64'd0);
    chk("mid_rst_idx", 64'(out_idx), 64'd0);
    chk("mid_rst_last", 64'(out_last), 64'd0);
    chk("mid_rst_ready", 64'(res_ready), 64'd1);
    chk("mid_rst_ovf", 64'({overflow, drop_cnt}), 64'd0);
    reset = 1'b0; out_ready = 1'b1;
    tick();
    strobe(SE, 1'b1);
    chk("post_rst_first", 64'({out_valid, out_data, out_idx}), 64'({1'b1, SE[127:96], 2'd0}));
    drain(1'b0);

    out_ready = 1'b0;
    strobe(SA, 1'b1);
    strobe(SB, 1'b1);
    for (int i = 0; i < 300; i++) strobe(SC, 1'b0);
    chk("sat_drop_cnt", 64'(drop_cnt), 64'd255);
    chk("sat_overflow", 64'(overflow), 64'd1);
    ovf_clear = 1'b1;
    strobe(SC, 1'b0);
    ovf_clear = 1'b0;
    chk("clr_drop_overflow", 64'(overflow), 64'd1);
    chk("clr_drop_cnt1", 64'(drop_cnt), 64'd1);
    ovf_clear = 1'b1; tick(); ovf_clear = 1'b0;
    chk("clr2_ovf", 64'({overflow, drop_cnt}), 64'd0);
    drain(1'b0);

    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
